// File: rtl/interval_sequencer_pkg.sv
// interval_sequencer_pkg
// Shared definitions for the interval sequencer: the FSM state encoding,
// the number of program slots and the width of one BCD byte.
// No ports; imported by interval_prog_regs and interval_sequencer.

package interval_sequencer_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_AW   = 2;
  localparam int BCD_W     = 8;

  // Encoding is visible on state_o, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALERT = 3'd4
  } state_t;

endpackage

// File: rtl/interval_sequencer_prog_regs.sv
// interval_prog_regs
// Four-slot program storage. Each slot holds a BCD minutes byte and a BCD
// seconds byte. One synchronous write port, one combinational read port.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-low reset; clears every slot to 00:00
//   we     - write strobe (already qualified by the caller)
//   waddr  - slot to write
//   wmins  - BCD minutes to write
//   wsecs  - BCD seconds to write
//   raddr  - slot to read
//   rmins  - BCD minutes of slot raddr
//   rsecs  - BCD seconds of slot raddr

module interval_prog_regs
  import interval_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [SLOT_AW-1:0] waddr,
  input  logic [BCD_W-1:0]   wmins,
  input  logic [BCD_W-1:0]   wsecs,
  input  logic [SLOT_AW-1:0] raddr,
  output logic [BCD_W-1:0]   rmins,
  output logic [BCD_W-1:0]   rsecs
);

  logic [BCD_W-1:0] mins_q [NUM_SLOTS];
  logic [BCD_W-1:0] secs_q [NUM_SLOTS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        mins_q[i] <= '0;
        secs_q[i] <= '0;
      end
    end else if (we) begin
      mins_q[waddr] <= wmins;
      secs_q[waddr] <= wsecs;
    end
  end

  assign rmins = mins_q[raddr];
  assign rsecs = secs_q[raddr];

endmodule

// File: rtl/interval_sequencer.sv
// interval_sequencer
// Control FSM for a multi-slot interval timer. It loads each programmed
// slot into an external BCD countdown datapath, enables decrements on the
// one-second tick, steps through slots and passes, and finally raises an
// alert for ALERT_SECS ticks (or until start_stop) before returning to idle.
//
// All inputs are single-cycle strobes or static levels; there is no
// backpressure anywhere, so every strobe is consumed in the cycle it is seen
// or dropped.
//
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   tick                 - one-cycle one-second strobe
//   start_stop           - one-cycle button pulse
//   prog_we/addr/mins/secs - slot programming (honoured only in IDLE)
//   num_slots            - active slots minus 1
//   repeats              - passes minus 1
//   secs_zero, mins_zero - zero flags from the countdown datapath
//   load, load_mins, load_secs - one-cycle load of the datapath
//   dec_en               - seconds-decrement enable to the datapath
//   slot_idx, pass_idx   - current slot and pass
//   state_o              - encoded FSM state (observability)
//   flash_en             - alert lights enable
//   done                 - one-cycle pulse on entering ALERT

module interval_sequencer
  import interval_sequencer_pkg::*;
#(
  parameter int ALERT_SECS = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start_stop,
  input  logic               prog_we,
  input  logic [SLOT_AW-1:0] prog_addr,
  input  logic [BCD_W-1:0]   prog_mins,
  input  logic [BCD_W-1:0]   prog_secs,
  input  logic [1:0]         num_slots,
  input  logic [3:0]         repeats,
  input  logic               secs_zero,
  input  logic               mins_zero,
  output logic               load,
  output logic [BCD_W-1:0]   load_mins,
  output logic [BCD_W-1:0]   load_secs,
  output logic               dec_en,
  output logic [1:0]         slot_idx,
  output logic [3:0]         pass_idx,
  output logic [2:0]         state_o,
  output logic               flash_en,
  output logic               done
);

  // Alert ends on the tick that sees the counter at ALERT_SECS-1.
  localparam logic [7:0] ALERT_LAST = 8'(ALERT_SECS - 1);

  state_t           state;
  logic [1:0]       slot_q;
  logic [3:0]       pass_q;
  logic [7:0]       alert_cnt;
  logic             done_q;
  logic [BCD_W-1:0] rd_mins;
  logic [BCD_W-1:0] rd_secs;
  logic             interval_end;
  logic             prog_wr;

  assign interval_end = secs_zero & mins_zero;
  assign prog_wr      = prog_we & (state == ST_IDLE);

  interval_prog_regs u_prog_regs (
    .clk   (clk),
    .reset (reset),
    .we    (prog_wr),
    .waddr (prog_addr),
    .wmins (prog_mins),
    .wsecs (prog_secs),
    .raddr (slot_q),
    .rmins (rd_mins),
    .rsecs (rd_secs)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      slot_q    <= '0;
      pass_q    <= '0;
      alert_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // tick is irrelevant here, so a coincident tick is simply ignored.
          if (start_stop) begin
            slot_q <= '0;
            pass_q <= '0;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          // Interval end is checked first so a coincident start_stop is dropped.
          if (interval_end) begin
            if (slot_q < num_slots) begin
              slot_q <= slot_q + 2'd1;
              state  <= ST_LOAD;
            end else if (pass_q < repeats) begin
              pass_q <= pass_q + 4'd1;
              slot_q <= '0;
              state  <= ST_LOAD;
            end else begin
              alert_cnt <= '0;
              done_q    <= 1'b1;
              state     <= ST_ALERT;
            end
          end else if (start_stop) begin
            state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start_stop) begin
            state <= ST_RUN;
          end
        end
        ST_ALERT: begin
          if (start_stop) begin
            alert_cnt <= '0;
            state     <= ST_IDLE;
          end else if (tick) begin
            if (alert_cnt == ALERT_LAST) begin
              alert_cnt <= '0;
              state     <= ST_IDLE;
            end else begin
              alert_cnt <= alert_cnt + 8'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode the registered state, so reset clears them at once.
  assign load      = (state == ST_LOAD);
  assign load_mins = load ? rd_mins : '0;
  assign load_secs = load ? rd_secs : '0;
  assign dec_en    = (state == ST_RUN) & tick & ~interval_end;
  assign flash_en  = (state == ST_ALERT);
  assign done      = done_q;
  assign slot_idx  = slot_q;
  assign pass_idx  = pass_q;
  assign state_o   = state;

endmodule

// File: tb/tb_interval_sequencer.sv
// Directed bench for interval_sequencer with a behavioural BCD countdown
// datapath closing the loop on secs_zero/mins_zero.

module tb_interval_sequencer;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start_stop;
  logic       prog_we;
  logic [1:0] prog_addr;
  logic [7:0] prog_mins;
  logic [7:0] prog_secs;
  logic [1:0] num_slots;
  logic [3:0] repeats;
  logic       secs_zero;
  logic       mins_zero;
  logic       load;
  logic [7:0] load_mins;
  logic [7:0] load_secs;
  logic       dec_en;
  logic [1:0] slot_idx;
  logic [3:0] pass_idx;
  logic [2:0] state_o;
  logic       flash_en;
  logic       done;

  interval_sequencer #(.ALERT_SECS(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start_stop (start_stop),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_mins  (prog_mins),
    .prog_secs  (prog_secs),
    .num_slots  (num_slots),
    .repeats    (repeats),
    .secs_zero  (secs_zero),
    .mins_zero  (mins_zero),
    .load       (load),
    .load_mins  (load_mins),
    .load_secs  (load_secs),
    .dec_en     (dec_en),
    .slot_idx   (slot_idx),
    .pass_idx   (pass_idx),
    .state_o    (state_o),
    .flash_en   (flash_en),
    .done       (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- countdown datapath model ----------------
  logic [7:0] dp_mins;
  logic [7:0] dp_secs;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_mins <= 8'h00;
      dp_secs <= 8'h00;
    end else if (load) begin
      dp_mins <= load_mins;
      dp_secs <= load_secs;
    end else if (dec_en) begin
      if (dp_secs == 8'h00) begin
        dp_secs <= 8'h59;
        dp_mins <= (dp_mins[3:0] == 4'd0) ? {dp_mins[7:4] - 4'd1, 4'd9} : dp_mins - 8'd1;
      end else begin
        dp_secs <= (dp_secs[3:0] == 4'd0) ? {dp_secs[7:4] - 4'd1, 4'd9} : dp_secs - 8'd1;
      end
    end
  end

  assign secs_zero = (dp_secs == 8'h00);
  assign mins_zero = (dp_mins == 8'h00);

  // ---------------- counters and capture ----------------
  int n_cmp = 0;
  int n_bad = 0;

  int         cyc;
  int         cnt_dec;
  int         cnt_done;
  int         dec_at_done;
  int         zero_viol = 0;
  int         flash_viol = 0;
  logic [15:0] load_q[$];
  logic [15:0] exp_q[$];
  int          dec_at_load_q[$];
  int          cyc_at_load_q[$];
  logic [3:0]  pass_at_load_q[$];
  logic        s_dec;
  logic        s_flash;
  logic [1:0]  s_slot;

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1: drives the strobes for one cycle, samples
  // the outputs at the falling edge, then lets the rising edge apply them.
  task automatic step(input logic t, input logic ss);
    tick       = t;
    start_stop = ss;
    @(negedge clk);
    s_dec   = dec_en;
    s_flash = flash_en;
    s_slot  = slot_idx;
    if (load) begin
      load_q.push_back({load_mins, load_secs});
      dec_at_load_q.push_back(cnt_dec);
      cyc_at_load_q.push_back(cyc);
      pass_at_load_q.push_back(pass_idx);
    end
    if (!load && (load_mins != 8'h00 || load_secs != 8'h00)) zero_viol++;
    if (flash_en && state_o != 3'd4) flash_viol++;
    if (dec_en) cnt_dec++;
    if (done) begin
      cnt_done++;
      dec_at_done = cnt_dec;
    end
    cyc++;
    @(posedge clk);
    #1;
    tick       = 1'b0;
    start_stop = 1'b0;
  endtask

  task automatic prog(input logic [1:0] a, input logic [7:0] m, input logic [7:0] s);
    prog_addr = a;
    prog_mins = m;
    prog_secs = s;
    prog_we   = 1'b1;
    step(1'b0, 1'b0);
    prog_we   = 1'b0;
  endtask

  task automatic clear_tally();
    cyc = 0;
    cnt_dec = 0;
    cnt_done = 0;
    dec_at_done = -1;
    load_q.delete();
    exp_q.delete();
    dec_at_load_q.delete();
    cyc_at_load_q.delete();
    pass_at_load_q.delete();
  endtask

  // Ticks on alternate cycles until ALERT or the cycle budget runs out.
  task automatic run_to_alert(input int budget);
    int i;
    i = 0;
    while (state_o != 3'd4 && i < budget) begin
      step((i % 2) == 0, 1'b0);
      i++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_cmp++; if ({load, dec_en, flash_en, done} !== 4'b0000) begin n_bad++; $display("FAIL reset_outputs: got %b want 0000", {load, dec_en, flash_en, done}); end
    n_cmp++; if ({slot_idx, pass_idx} !== 6'd0) begin n_bad++; $display("FAIL reset_indices: got %0d/%0d want 0/0", slot_idx, pass_idx); end
    num_slots = 2'd0;
    repeats   = 4'd0;
    clear_tally();
    step(1'b0, 1'b1);
    n_cmp++; if (state_o !== 3'd1) begin n_bad++; $display("FAIL first_start: got state %0d want 1", state_o); end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_cmp++; if (load_q.size() !== 1 || load_q[0] !== 16'h0000) begin n_bad++; $display("FAIL reset_slot0: got %h want 0000", load_q[0]); end
    n_cmp++; if (state_o !== 3'd4) begin n_bad++; $display("FAIL empty_slot_alert: got state %0d want 4", state_o); end
    step(1'b0, 1'b1);
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL alert_button_exit: got state %0d want 0", state_o); end
  endtask

  task automatic test_basic_run();
    int n;
    int guard;
    prog(2'd0, 8'h00, 8'h05);
    prog(2'd1, 8'h00, 8'h03);
    num_slots = 2'd1;
    repeats   = 4'd0;
    clear_tally();
    exp_q.push_back(16'h0005);
    exp_q.push_back(16'h0003);
    step(1'b0, 1'b1);
    run_to_alert(200);
    n_cmp++; if (state_o !== 3'd4) begin n_bad++; $display("FAIL basic_reach_alert: got state %0d want 4", state_o); end
    n_cmp++; if (load_q.size() !== 2) begin n_bad++; $display("FAIL basic_load_count: got %0d want 2", load_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (load_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_load_value[%0d]: got %h want %h", i, load_q[i], exp_q[i]); end
    end
    n_cmp++; if (dec_at_load_q[1] !== 5) begin n_bad++; $display("FAIL basic_dec_slot0: got %0d want 5", dec_at_load_q[1]); end
    n_cmp++; if (cnt_dec !== 8) begin n_bad++; $display("FAIL basic_dec_total: got %0d want 8", cnt_dec); end
    n = 0;
    guard = 0;
    while (state_o == 3'd4 && guard < 40) begin
      step(1'b1, 1'b0);
      if (s_flash) n++;
      guard++;
    end
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL basic_alert_ticks: got %0d want 10", n); end
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL basic_alert_exit: got state %0d want 0", state_o); end
    n_cmp++; if (cnt_done !== 1) begin n_bad++; $display("FAIL basic_done_pulses: got %0d want 1", cnt_done); end
  endtask

  task automatic test_repeats();
    prog(2'd0, 8'h00, 8'h02);
    num_slots = 2'd0;
    repeats   = 4'd2;
    clear_tally();
    step(1'b0, 1'b1);
    run_to_alert(200);
    n_cmp++; if (load_q.size() !== 3) begin n_bad++; $display("FAIL rep_load_count: got %0d want 3", load_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (pass_at_load_q[i] !== 4'(i)) begin n_bad++; $display("FAIL rep_pass_idx[%0d]: got %0d want %0d", i, pass_at_load_q[i], i); end
    end
    step(1'b1, 1'b1);
    n_cmp++; if (dec_at_done !== 6) begin n_bad++; $display("FAIL rep_done_after: got %0d want 6", dec_at_done); end
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL rep_button_over_tick: got state %0d want 0", state_o); end
  endtask

  task automatic test_pause();
    int d0;
    int guard;
    prog(2'd0, 8'h00, 8'h01);
    prog(2'd1, 8'h00, 8'h04);
    num_slots = 2'd1;
    repeats   = 4'd0;
    clear_tally();
    step(1'b0, 1'b1);
    guard = 0;
    while (!(state_o == 3'd2 && slot_idx == 2'd1) && guard < 40) begin
      step(1'b1, 1'b0);
      guard++;
    end
    n_cmp++; if (state_o !== 3'd2 || slot_idx !== 2'd1) begin n_bad++; $display("FAIL pause_reach_slot1: got state %0d slot %0d want 2/1", state_o, slot_idx); end
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL pause_enter: got state %0d want 3", state_o); end
    d0 = cnt_dec;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      n_cmp++; if (s_dec !== 1'b0) begin n_bad++; $display("FAIL pause_dec[%0d]: got %b want 0", i, s_dec); end
      n_cmp++; if (s_slot !== 2'd1) begin n_bad++; $display("FAIL pause_slot[%0d]: got %0d want 1", i, s_slot); end
    end
    n_cmp++; if (cnt_dec !== d0) begin n_bad++; $display("FAIL pause_dec_frozen: got %0d want %0d", cnt_dec, d0); end
    step(1'b0, 1'b1);
    n_cmp++; if (state_o !== 3'd2) begin n_bad++; $display("FAIL pause_resume: got state %0d want 2", state_o); end
    run_to_alert(200);
    n_cmp++; if (cnt_dec !== 5) begin n_bad++; $display("FAIL pause_dec_total: got %0d want 5", cnt_dec); end
    step(1'b0, 1'b1);
  endtask

  task automatic test_zero_slot();
    prog(2'd0, 8'h00, 8'h01);
    prog(2'd1, 8'h00, 8'h00);
    prog(2'd2, 8'h00, 8'h02);
    num_slots = 2'd2;
    repeats   = 4'd0;
    clear_tally();
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0002);
    step(1'b0, 1'b1);
    run_to_alert(200);
    n_cmp++; if (load_q.size() !== 3) begin n_bad++; $display("FAIL zero_load_count: got %0d want 3", load_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (load_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL zero_load_value[%0d]: got %h want %h", i, load_q[i], exp_q[i]); end
    end
    n_cmp++; if (cyc_at_load_q[2] - cyc_at_load_q[1] !== 2) begin n_bad++; $display("FAIL zero_skip_cycles: got %0d want 2", cyc_at_load_q[2] - cyc_at_load_q[1]); end
    n_cmp++; if (dec_at_load_q[2] !== dec_at_load_q[1]) begin n_bad++; $display("FAIL zero_skip_dec: got %0d want %0d", dec_at_load_q[2], dec_at_load_q[1]); end
    n_cmp++; if (cnt_dec !== 3) begin n_bad++; $display("FAIL zero_dec_total: got %0d want 3", cnt_dec); end
    step(1'b0, 1'b1);
  endtask

  task automatic test_collisions();
    prog(2'd0, 8'h00, 8'h01);
    prog(2'd1, 8'h00, 8'h01);
    num_slots = 2'd1;
    repeats   = 4'd0;
    clear_tally();
    step(1'b1, 1'b1);
    n_cmp++; if (state_o !== 3'd1) begin n_bad++; $display("FAIL coll_idle_tick_start: got state %0d want 1", state_o); end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    n_cmp++; if (state_o !== 3'd1 || slot_idx !== 2'd1) begin n_bad++; $display("FAIL coll_end_beats_pause: got state %0d slot %0d want 1/1", state_o, slot_idx); end
    step(1'b0, 1'b0);
    prog(2'd1, 8'h09, 8'h59);
    run_to_alert(200);
    n_cmp++; if (state_o !== 3'd4) begin n_bad++; $display("FAIL coll_reach_alert: got state %0d want 4", state_o); end
    step(1'b0, 1'b1);
    clear_tally();
    step(1'b0, 1'b1);
    run_to_alert(200);
    n_cmp++; if (load_q.size() !== 2 || load_q[1] !== 16'h0001) begin n_bad++; $display("FAIL coll_prog_in_run: got %h want 0001", load_q[1]); end
    step(1'b0, 1'b1);
  endtask

  task automatic test_reset_in_alert();
    prog(2'd0, 8'h00, 8'h01);
    prog(2'd3, 8'h00, 8'h07);
    num_slots = 2'd0;
    repeats   = 4'd0;
    clear_tally();
    step(1'b0, 1'b1);
    run_to_alert(50);
    n_cmp++; if (flash_en !== 1'b1) begin n_bad++; $display("FAIL rst_alert_flash_before: got %b want 1", flash_en); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (flash_en !== 1'b0) begin n_bad++; $display("FAIL rst_async_flash: got %b want 0", flash_en); end
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL rst_async_state: got %0d want 0", state_o); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    num_slots = 2'd3;
    clear_tally();
    step(1'b0, 1'b1);
    n_cmp++; if (state_o !== 3'd1) begin n_bad++; $display("FAIL rst_first_start: got state %0d want 1", state_o); end
    run_to_alert(50);
    n_cmp++; if (load_q.size() !== 4) begin n_bad++; $display("FAIL rst_slot_loads: got %0d want 4", load_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (load_q[i] !== 16'h0000) begin n_bad++; $display("FAIL rst_slot_clear[%0d]: got %h want 0000", i, load_q[i]); end
    end
    step(1'b0, 1'b1);
  endtask

  task automatic test_output_gating();
    n_cmp++; if (zero_viol !== 0) begin n_bad++; $display("FAIL load_value_gating: got %0d cycles want 0", zero_viol); end
    n_cmp++; if (flash_viol !== 0) begin n_bad++; $display("FAIL flash_outside_alert: got %0d cycles want 0", flash_viol); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    reset      = 1'b0;
    tick       = 1'b0;
    start_stop = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = 2'd0;
    prog_mins  = 8'h00;
    prog_secs  = 8'h00;
    num_slots  = 2'd0;
    repeats    = 4'd0;
    clear_tally();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    test_reset();
    test_basic_run();
    test_repeats();
    test_pause();
    test_zero_slot();
    test_collisions();
    test_reset_in_alert();
    test_output_gating();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
